// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver:
// scan state encoding, the hex font table and output polarity helpers.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Active-high segment patterns for hex digits 0-F, bit6..bit0 = g..a.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam bit POL_ACTIVE_LOW  = 1'b1;
  localparam bit POL_ACTIVE_HIGH = 1'b0;

  // Convert an active-high segment pattern to the pin polarity.
  function automatic logic [6:0] seg_drive(input logic [6:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex to 7-segment lookup (active-high patterns).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver. Advances one digit per rising edge of
// the divided scan_in wave, inserts an all-anodes-off gap after every digit
// switch, and commits newly loaded values only at frame boundaries.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int BLANK_CYCLES   = 2,
  parameter bit AN_ACTIVE_LOW  = POL_ACTIVE_LOW,
  parameter bit SEG_ACTIVE_LOW = POL_ACTIVE_LOW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_in,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic s1, s2, s3, step;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic wrap;
  logic [4*NUM_DIGITS-1:0] pending, shown;
  logic pend_flag;
  logic [3:0] nibble;
  logic [6:0] font_seg;
  logic [NUM_DIGITS-1:0] an_hi;
  logic lit;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0] seg_q;
  logic fs_q;

  // Synchronise scan_in and keep one extra stage for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= scan_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step = s2 & ~s3;

  // Scan state, blank counter and digit index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= CNT_LOAD;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic: a step always advances the index and (re)starts the blank gap.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    wrap    = 1'b0;
    if (step) begin
      wrap    = (idx == LAST_IDX);
      idx_n   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      state_n = BLANK;
      cnt_n   = CNT_LOAD;
    end else if (state == BLANK) begin
      cnt_n = cnt - 1'b1;
      if (cnt == CNT_W'(1)) state_n = SHOW;
    end
  end

  // Pending/shown value registers; shown only changes at a frame wrap.
  // NOTE: the value registers are reset as well, because a reset must
  // discard any pending load and show zero until the next commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      shown     <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (wrap && pend_flag) shown <= pending;
      if (load) begin
        pending   <= data_in;
        pend_flag <= 1'b1;
      end else if (wrap && pend_flag) begin
        pend_flag <= 1'b0;
      end
    end
  end

  assign nibble = shown[{idx, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (font_seg)
  );

  // One-hot active-high anode select for the current index.
  always_comb begin
    an_hi      = '0;
    an_hi[idx] = 1'b1;
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [IDX_W-1:0] msd;

  // Position of the most significant nonzero nibble of the shown value (0 if all zero).
  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (shown[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    end
  end

  assign lit = (idx <= msd);
`else
  assign lit = 1'b1;
`endif

  // Registered pin outputs: anodes and segments only driven while showing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= wrap;
      if (state == SHOW) begin
        an_q  <= (digit_en[idx] && lit) ? (AN_ACTIVE_LOW ? ~an_hi : an_hi) : AN_OFF;
        seg_q <= seg_drive(font_seg, SEG_ACTIVE_LOW);
      end else begin
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
      end
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = SEG_ACTIVE_LOW;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (8 digits, 2 blank
// cycles, active-low anodes and segments).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_in;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  digit_en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int errors   = 0;
  int checks   = 0;
  int fs_count = 0;
  int cur_idx  = 0;
`ifdef SEG7_LZ_BLANK_EN
  bit lz_on = 1'b1;
`else
  bit lz_on = 1'b0;
`endif

  seg7_scan_driver #(
    .NUM_DIGITS     (8),
    .BLANK_CYCLES   (2),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_in     (scan_in),
    .data_in     (data_in),
    .load        (load),
    .digit_en    (digit_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_start === 1'b1) fs_count++;
  endtask

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic bit lit(input logic [31:0] v, input int idx);
    int msd = 0;
    for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) msd = i;
    return !lz_on || (idx <= msd);
  endfunction

  task automatic do_load(input logic [31:0] v);
    data_in = v;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // One scan_in rising edge: expect two blank cycles, then the next digit.
  task automatic step_chk(input string tag, input logic [31:0] shown_v,
                          input bit do_ld = 1'b0, input logic [31:0] ld = 32'h0);
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    cur_idx = (cur_idx + 1) % 8;
    scan_in = 1'b1;
    tick();
    scan_in = 1'b0;
    tick();
    if (do_ld) begin
      data_in = ld;
      load    = 1'b1;
    end
    tick();
    load = 1'b0;
    tick();
    check({tag, "_blank1"}, an, 8'hFF);
    tick();
    check({tag, "_blank2"}, an, 8'hFF);
    tick();
    exp_an  = (digit_en[cur_idx] && lit(shown_v, cur_idx)) ? ~(8'h01 << cur_idx) : 8'hFF;
    exp_seg = ~font(shown_v[4*cur_idx +: 4]);
    check({tag, "_an"}, an, exp_an);
    if (exp_an != 8'hFF) check({tag, "_seg"}, seg, exp_seg);
  endtask

  // Eight steps from digit 0 back to digit 0; the final digit-0 slot shows final_v.
  task automatic walk_frame(input string tag, input logic [31:0] shown_v, input logic [31:0] final_v);
    int f0 = fs_count;
    for (int i = 1; i < 8; i++) step_chk($sformatf("%s_d%0d", tag, i), shown_v);
    step_chk($sformatf("%s_d0", tag), final_v);
    check({tag, "_fs"}, 32'(fs_count - f0), 32'd1);
  endtask

  task automatic reset_release(input string tag);
    rst     = 1'b0;
    cur_idx = 0;
    tick();
    check({tag, "_blank1"}, an, 8'hFF);
    tick();
    check({tag, "_blank2"}, an, 8'hFF);
    tick();
    check({tag, "_an"}, an, 8'hFE);
    check({tag, "_seg"}, seg, 7'h40);
  endtask

  initial begin
    int f0;
    rst      = 1'b1;
    scan_in  = 1'b0;
    load     = 1'b0;
    data_in  = 32'h0;
    digit_en = 8'hFF;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset defaults
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_fs", frame_start, 1'b0);
    reset_release("rel");

    // 2: mid-frame load at index 3, commit at wrap
    step_chk("t2_1", 32'h0);
    step_chk("t2_2", 32'h0);
    step_chk("t2_3", 32'h0);
    do_load(32'h1234_5678);
    for (int i = 4; i < 8; i++) step_chk($sformatf("t2_%0d", i), 32'h0);
    f0 = fs_count;
    step_chk("t2_wrap", 32'h1234_5678);
    check("t2_fs", 32'(fs_count - f0), 32'd1);
    check("t2_d0_seg8", seg, 7'h00);

    // 3: full walk, digit 7 shows '1'
    walk_frame("t3", 32'h1234_5678, 32'h1234_5678);

    // 4: digit enable mask
    digit_en = 8'h0F;
    walk_frame("t4", 32'h1234_5678, 32'h1234_5678);
    digit_en = 8'hFF;

    // load coincident with wrap: old pending commits, new stays pending
    for (int i = 1; i < 7; i++) step_chk($sformatf("lw_%0d", i), 32'h1234_5678);
    do_load(32'hFEDC_BA98);
    step_chk("lw_7", 32'h1234_5678);
    step_chk("lw_wrap", 32'hFEDC_BA98, 1'b1, 32'h0F1E_2D3C);
    walk_frame("lw2", 32'hFEDC_BA98, 32'h0F1E_2D3C);

    // 5: reset during SHOW at index 5 with a pending load
    for (int i = 1; i < 6; i++) step_chk($sformatf("t5_%0d", i), 32'h0F1E_2D3C);
    do_load(32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    check("t5_async_an", an, 8'hFF);
    check("t5_async_seg", seg, 7'h7F);
    tick();
    reset_release("t5_rel");
    walk_frame("t5_walk", 32'h0, 32'h0);

    // 6: leading-zero behaviour (all digits lit when the option is off)
    do_load(32'h0000_00A5);
    walk_frame("t6a", 32'h0, 32'h0000_00A5);
    walk_frame("t6b", 32'h0000_00A5, 32'h0000_00A5);
    do_load(32'h0);
    walk_frame("t6c", 32'h0000_00A5, 32'h0);
    walk_frame("t6d", 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
